// File: rtl/axi_sram_bridge_mo.sv
// Bridges the CPU's inst (read-only) and data (read/write) SRAM-like ports onto one AXI3 master,
// with up to MAX_OUT outstanding reads per port and in-order data_ok on each port.
module axi_sram_bridge_mo #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  // inst port
  input  logic                  inst_req,
  input  logic                  inst_wr,
  input  logic [1:0]            inst_size,
  input  logic [ADDR_W-1:0]     inst_addr,
  input  logic [DATA_W/8-1:0]   inst_wstrb,
  input  logic [DATA_W-1:0]     inst_wdata,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,
  // data port
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  // AR channel
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  // R channel
  input  logic [3:0]            rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  // AW channel
  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  // W channel
  output logic [3:0]            wid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // B channel
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUT);

  logic [CW-1:0]         cnt_i_q, cnt_i_d, cnt_d_q, cnt_d_d;
  logic                  wbusy_q, wbusy_d;
  logic                  arvalid_q, arvalid_d;
  logic                  arid_q, arid_d;
  logic [ADDR_W-1:0]     araddr_q, araddr_d;
  logic [1:0]            arsize_q, arsize_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
  logic [1:0]            awsize_q, awsize_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  rready_q;
  logic [DATA_W-1:0]     inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
  logic                  inst_dok_q, inst_dok_d, data_dok_q, data_dok_d;

  logic r_hs, b_hs, ar_free, d_rd_ok, i_rd_ok, pick_d, pick_i, wr_acc;
  logic dec_i, dec_d;
  logic unused_inputs;

  assign unused_inputs = ^{inst_wr, inst_wstrb, inst_wdata, rid[3:1], rresp, rlast, bid, bresp};

  assign r_hs    = rvalid && rready_q;
  assign bready  = wbusy_q && !awvalid_q && !wvalid_q;
  assign b_hs    = bvalid && bready;
  assign ar_free = !arvalid_q || arready;

  // Data reads win the AR slot; counts compare against registered values only.
  assign d_rd_ok = data_req && !data_wr && (cnt_d_q < MaxCnt) && !wbusy_q;
  assign i_rd_ok = inst_req && (cnt_i_q < MaxCnt);
  assign pick_d  = !areset && ar_free && d_rd_ok;
  assign pick_i  = !areset && ar_free && !d_rd_ok && i_rd_ok;
  // Writes wait for all data reads to drain so data_ok stays in request order.
  assign wr_acc  = !areset && data_req && data_wr && !wbusy_q && (cnt_d_q == '0);

  assign dec_i = r_hs && !rid[0];
  assign dec_d = r_hs && rid[0];

  assign inst_addr_ok = pick_i;
  assign data_addr_ok = pick_d || wr_acc;

  always_comb begin
    cnt_i_d      = cnt_i_q;
    cnt_d_d      = cnt_d_q;
    wbusy_d      = wbusy_q;
    arvalid_d    = arvalid_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arsize_d     = arsize_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    awaddr_d     = awaddr_q;
    awsize_d     = awsize_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_dok_d   = dec_i;
    data_dok_d   = dec_d || b_hs;

    if (pick_i && !dec_i) begin
      cnt_i_d = cnt_i_q + CW'(1);
    end else if (!pick_i && dec_i) begin
      cnt_i_d = cnt_i_q - CW'(1);
    end
    if (pick_d && !dec_d) begin
      cnt_d_d = cnt_d_q + CW'(1);
    end else if (!pick_d && dec_d) begin
      cnt_d_d = cnt_d_q - CW'(1);
    end

    if (pick_d || pick_i) begin
      arvalid_d = 1'b1;
      arid_d    = pick_d;
      araddr_d  = pick_d ? data_addr : inst_addr;
      arsize_d  = pick_d ? data_size : inst_size;
    end else if (arvalid_q && arready) begin
      arvalid_d = 1'b0;
    end

    if (dec_i) inst_rdata_d = rdata;
    if (dec_d) data_rdata_d = rdata;

    if (wr_acc) begin
      wbusy_d   = 1'b1;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = data_addr;
      awsize_d  = data_size;
      wstrb_d   = data_wstrb;
      wdata_d   = data_wdata;
    end else begin
      if (awvalid_q && awready) awvalid_d = 1'b0;
      if (wvalid_q && wready)   wvalid_d  = 1'b0;
      if (b_hs)                 wbusy_d   = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_i_q      <= '0;
      cnt_d_q      <= '0;
      wbusy_q      <= 1'b0;
      arvalid_q    <= 1'b0;
      arid_q       <= 1'b0;
      araddr_q     <= '0;
      arsize_q     <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      awaddr_q     <= '0;
      awsize_q     <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      rready_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_dok_q   <= 1'b0;
      data_dok_q   <= 1'b0;
    end else begin
      cnt_i_q      <= cnt_i_d;
      cnt_d_q      <= cnt_d_d;
      wbusy_q      <= wbusy_d;
      arvalid_q    <= arvalid_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arsize_q     <= arsize_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      awaddr_q     <= awaddr_d;
      awsize_q     <= awsize_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      rready_q     <= 1'b1;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_dok_q   <= inst_dok_d;
      data_dok_q   <= data_dok_d;
    end
  end

  assign inst_data_ok = inst_dok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_data_ok = data_dok_q;
  assign data_rdata   = data_rdata_q;

  assign arid    = {3'b000, arid_q};
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, arsize_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = 4'd1;
  assign awaddr  = awaddr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, awsize_q};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_q;

  assign wid     = 4'd1;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;

endmodule

// File: tb/tb_axi_sram_bridge_mo.sv
// Directed self-checking bench for axi_sram_bridge_mo; the AXI slave is driven cycle by cycle.
module tb_axi_sram_bridge_mo;

  logic        aclk, areset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int nvec = 0;
  int nerr = 0;

  axi_sram_bridge_mo dut (
    .aclk(aclk), .areset(areset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Step to 1 time unit after the next rising edge.
  task automatic cyc;
    @(posedge aclk);
    #1;
  endtask

  // Resets DUT and idles the bench-side slave and both CPU ports.
  task automatic do_reset;
    cyc();
    areset = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    cyc();
    cyc();
    areset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    cyc();
    #1;
    nvec++;
    if ({arvalid, awvalid, wvalid, bready} !== 4'b0000) begin
      nerr++; $display("FAIL reset_valids: got %b want 0000", {arvalid, awvalid, wvalid, bready});
    end
    nvec++;
    if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0000) begin
      nerr++; $display("FAIL reset_oks: got %b want 0000",
                       {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    nvec++;
    if ({inst_rdata, data_rdata, araddr, awaddr, wdata} !== 160'd0) begin
      nerr++; $display("FAIL reset_data: got %h want 0", {inst_rdata, data_rdata, araddr});
    end
    nvec++;
    if ({arid, arsize, awsize, wstrb, rready} !== 15'b0000_000_000_0000_1) begin
      nerr++; $display("FAIL reset_misc: got %b want 000000000000001",
                       {arid, arsize, awsize, wstrb, rready});
    end
  endtask

  task automatic test_inst_read;
    do_reset();
    cyc(); // t0
    inst_req = 1; inst_addr = 32'h1000; arready = 1;
    #1;
    nvec++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      nerr++; $display("FAIL ird_addr_ok: got %b want 10", {inst_addr_ok, data_addr_ok});
    end
    cyc(); // t1
    inst_req = 0;
    #1;
    nvec++;
    if ({arvalid, arid, araddr, arsize, arlen, arburst} !== {1'b1, 4'd0, 32'h1000, 3'd2, 8'd0, 2'b01})
    begin
      nerr++; $display("FAIL ird_ar: got %b %h %h %h want 1 0 1000 2", arvalid, arid, araddr, arsize);
    end
    cyc(); // t2
    rvalid = 1; rid = 0; rdata = 32'hDEADBEEF;
    #1;
    nvec++;
    if ({inst_data_ok, arvalid} !== 2'b00) begin
      nerr++; $display("FAIL ird_t2: got %b want 00", {inst_data_ok, arvalid});
    end
    cyc(); // t3
    rvalid = 0;
    #1;
    nvec++;
    if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      nerr++; $display("FAIL ird_t3: got %b %b %h want 1 0 deadbeef",
                       inst_data_ok, data_data_ok, inst_rdata);
    end
    cyc();
    #1;
    nvec++;
    if (inst_data_ok !== 1'b0) begin
      nerr++; $display("FAIL ird_pulse: got %b want 0", inst_data_ok);
    end
  endtask

  task automatic test_priority;
    do_reset();
    cyc(); // t0
    inst_req = 1; inst_addr = 32'h2000; data_req = 1; data_addr = 32'h3000; arready = 1;
    #1;
    nvec++;
    if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      nerr++; $display("FAIL prio_t0: got %b want 10", {data_addr_ok, inst_addr_ok});
    end
    cyc(); // t1
    data_req = 0;
    #1;
    nvec++;
    if ({arvalid, arid, araddr, inst_addr_ok} !== {1'b1, 4'd1, 32'h3000, 1'b1}) begin
      nerr++; $display("FAIL prio_t1: got %b %h %h %b want 1 1 3000 1",
                       arvalid, arid, araddr, inst_addr_ok);
    end
    cyc(); // t2
    inst_req = 0; rvalid = 1; rid = 1; rdata = 32'hAAAA5555;
    #1;
    nvec++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h2000}) begin
      nerr++; $display("FAIL prio_t2: got %b %h %h want 1 0 2000", arvalid, arid, araddr);
    end
    cyc(); // t3
    rid = 0; rdata = 32'h11112222;
    #1;
    nvec++;
    if ({data_data_ok, inst_data_ok, data_rdata, inst_rdata} !== {2'b10, 32'hAAAA5555, 32'h0})
    begin
      nerr++; $display("FAIL prio_t3: got %b %b %h %h want 1 0 aaaa5555 0",
                       data_data_ok, inst_data_ok, data_rdata, inst_rdata);
    end
    cyc(); // t4
    rvalid = 0;
    #1;
    nvec++;
    if ({data_data_ok, inst_data_ok, data_rdata, inst_rdata}
        !== {2'b01, 32'hAAAA5555, 32'h11112222}) begin
      nerr++; $display("FAIL prio_t4: got %b %b %h %h want 0 1 aaaa5555 11112222",
                       data_data_ok, inst_data_ok, data_rdata, inst_rdata);
    end
  endtask

  task automatic test_max_out;
    int acc;
    do_reset();
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      inst_req = 1; inst_addr = 32'h4000 + 32'(k * 4); arready = 1;
      #1;
      acc = acc + int'(inst_addr_ok);
    end
    nvec++;
    if (acc !== 4) begin
      nerr++; $display("FAIL max_accepts: got %0d want 4", acc);
    end
    nvec++;
    if (inst_addr_ok !== 1'b0) begin
      nerr++; $display("FAIL max_blocked: got %b want 0", inst_addr_ok);
    end
    cyc();
    rvalid = 1; rid = 0; rdata = 32'h55;
    #1;
    nvec++;
    if (inst_addr_ok !== 1'b0) begin
      nerr++; $display("FAIL max_same_cycle: got %b want 0", inst_addr_ok);
    end
    cyc();
    rvalid = 0;
    #1;
    nvec++;
    if (inst_addr_ok !== 1'b1) begin
      nerr++; $display("FAIL max_unblock: got %b want 1", inst_addr_ok);
    end
    cyc();
    #1;
    nvec++;
    if (inst_addr_ok !== 1'b0) begin
      nerr++; $display("FAIL max_reblock: got %b want 0", inst_addr_ok);
    end
  endtask

  task automatic test_write;
    do_reset();
    cyc(); // t0
    data_req = 1; data_wr = 1; data_addr = 32'h20; data_wstrb = 4'hF; data_wdata = 32'h1234;
    wready = 1; awready = 0;
    #1;
    nvec++;
    if (data_addr_ok !== 1'b1) begin
      nerr++; $display("FAIL wr_accept: got %b want 1", data_addr_ok);
    end
    cyc(); // t1: data read now queued behind the write
    data_wr = 0; data_addr = 32'h40;
    #1;
    nvec++;
    if ({awvalid, wvalid, bready, data_addr_ok, awaddr, wdata, wstrb, awid, wid, wlast}
        !== {4'b1100, 32'h20, 32'h1234, 4'hF, 4'd1, 4'd1, 1'b1}) begin
      nerr++; $display("FAIL wr_t1: got %b%b%b%b %h %h %h want 1100 20 1234 f",
                       awvalid, wvalid, bready, data_addr_ok, awaddr, wdata, wstrb);
    end
    for (int k = 2; k <= 4; k++) begin
      cyc();
      if (k == 4) awready = 1;
      #1;
      nvec++;
      if ({awvalid, wvalid, bready, data_addr_ok} !== 4'b1000) begin
        nerr++; $display("FAIL wr_hold_t%0d: got %b want 1000",
                         k, {awvalid, wvalid, bready, data_addr_ok});
      end
    end
    cyc(); // t5
    awready = 0; bvalid = 1; bid = 1;
    #1;
    nvec++;
    if ({awvalid, wvalid, bready, data_addr_ok, data_data_ok} !== 5'b00100) begin
      nerr++; $display("FAIL wr_bready: got %b want 00100",
                       {awvalid, wvalid, bready, data_addr_ok, data_data_ok});
    end
    cyc(); // t6
    bvalid = 0; arready = 1;
    #1;
    nvec++;
    if ({data_data_ok, bready, data_addr_ok} !== 3'b101) begin
      nerr++; $display("FAIL wr_done: got %b want 101", {data_data_ok, bready, data_addr_ok});
    end
    cyc(); // t7
    data_req = 0;
    #1;
    nvec++;
    if ({data_data_ok, arvalid, arid, araddr} !== {2'b01, 4'd1, 32'h40}) begin
      nerr++; $display("FAIL wr_then_rd: got %b %b %h %h want 0 1 1 40",
                       data_data_ok, arvalid, arid, araddr);
    end
  endtask

  task automatic test_write_after_reads;
    do_reset();
    cyc();
    data_req = 1; data_addr = 32'h100; arready = 1;
    cyc();
    data_addr = 32'h104;
    cyc();
    data_wr = 1; data_addr = 32'h200; data_wdata = 32'hCAFE; data_wstrb = 4'h3;
    #1;
    nvec++;
    if (data_addr_ok !== 1'b0) begin
      nerr++; $display("FAIL wbr_cnt2: got %b want 0", data_addr_ok);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      rvalid = 1; rid = 1; rdata = 32'h77 + 32'(k);
      #1;
      nvec++;
      if (data_addr_ok !== 1'b0) begin
        nerr++; $display("FAIL wbr_drain%0d: got %b want 0", k, data_addr_ok);
      end
    end
    cyc();
    rvalid = 0;
    #1;
    nvec++;
    if (data_addr_ok !== 1'b1) begin
      nerr++; $display("FAIL wbr_accept: got %b want 1", data_addr_ok);
    end
    cyc();
    data_req = 0;
    #1;
    nvec++;
    if ({awvalid, wvalid, awaddr, wdata, wstrb} !== {2'b11, 32'h200, 32'hCAFE, 4'h3}) begin
      nerr++; $display("FAIL wbr_aw: got %b%b %h %h %h want 11 200 cafe 3",
                       awvalid, wvalid, awaddr, wdata, wstrb);
    end
  endtask

  task automatic test_mid_reset;
    int acc;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc();
      inst_req = 1; inst_addr = 32'h500 + 32'(k * 4); arready = 1;
    end
    cyc();
    inst_req = 0; arready = 0;
    #1;
    nvec++;
    if (arvalid !== 1'b1) begin
      nerr++; $display("FAIL mr_pre: got %b want 1", arvalid);
    end
    areset = 1;
    cyc();
    #1;
    nvec++;
    if ({arvalid, awvalid, wvalid, bready, rready, inst_data_ok} !== 6'b000000) begin
      nerr++; $display("FAIL mr_cleared: got %b want 000000",
                       {arvalid, awvalid, wvalid, bready, rready, inst_data_ok});
    end
    cyc();
    areset = 0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      inst_req = 1; inst_addr = 32'h600 + 32'(k * 4); arready = 1;
      #1;
      acc = acc + int'(inst_addr_ok);
    end
    nvec++;
    if (acc !== 4) begin
      nerr++; $display("FAIL mr_counter: got %0d accepts want 4", acc);
    end
  endtask

  initial begin
    areset = 1'b1;
    test_reset();
    test_inst_read();
    test_priority();
    test_max_out();
    test_write();
    test_write_after_reads();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
